// File: rtl/pdp6_console_pkg.sv
// Shared constants and helpers for the console key conditioning logic.
// Repeat-related defaults are only consumed when KEY_RPT_EN is defined.
package pdp6_console_pkg;

  localparam int unsigned DEF_N       = 8;
  localparam int unsigned DEF_SETTLE  = 1000;
  localparam int unsigned DEF_CW      = 10;
  localparam int unsigned DEF_RW      = 16;
  localparam int unsigned DEF_RPT_DLY = 30000;
  localparam int unsigned DEF_RPT_PER = 10000;

  // Smallest width able to hold the values 0 .. cycles-1 (never below 1).
  function automatic int unsigned min_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << w) < cycles) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: two-flop synchroniser, settle counter, and (with KEY_RPT_EN)
// an auto-repeat counter that pulses while the debounced level is high.
module key_debounce_bit
  import pdp6_console_pkg::*;
#(
  parameter int unsigned SETTLE  = DEF_SETTLE,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned RW      = DEF_RW,
  parameter int unsigned RPT_DLY = DEF_RPT_DLY,
  parameter int unsigned RPT_PER = DEF_RPT_PER
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_out,
  output logic diff,
  output logic rpt
);

  logic          s1_q, s2_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_in;
      s2_q  <= s1_q;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  // Any cycle where the synchronised level agrees with the output restarts the count.
  always_comb begin
    diff  = s2_q ^ out_q;
    out_d = out_q;
    cnt_d = cnt_q;
    if (!diff) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(SETTLE - 1)) begin
      out_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign key_out = out_q;

`ifdef KEY_RPT_EN
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end

  // Reloading to DLY-PER on each pulse makes every later interval PER cycles.
  always_comb begin
    rpt_hit = (rcnt_q == RW'(RPT_DLY - 1));
    rpt     = out_q & rpt_hit;
    rcnt_d  = rcnt_q + RW'(1);
    if (!out_q)       rcnt_d = '0;
    else if (rpt_hit) rcnt_d = RW'(RPT_DLY - RPT_PER);
  end
`else
  logic cfg_unused;
  assign cfg_unused = (RW + RPT_DLY + RPT_PER) != 0;
  assign rpt        = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces a bank of N asynchronous console keys; optional auto-repeat
// pulses are built when KEY_RPT_EN is defined.
module key_debounce
  import pdp6_console_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned SETTLE  = DEF_SETTLE,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned RW      = DEF_RW,
  parameter int unsigned RPT_DLY = DEF_RPT_DLY,
  parameter int unsigned RPT_PER = DEF_RPT_PER
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] keys_in,
  output logic [N-1:0] keys_out,
  output logic         settling,
  output logic [N-1:0] rpt
);

  logic [N-1:0] diff_w;

  for (genvar i = 0; i < N; i++) begin : g_key
    key_debounce_bit #(
      .SETTLE (SETTLE),
      .CW     (CW),
      .RW     (RW),
      .RPT_DLY(RPT_DLY),
      .RPT_PER(RPT_PER)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .key_in (keys_in[i]),
      .key_out(keys_out[i]),
      .diff   (diff_w[i]),
      .rpt    (rpt[i])
    );
  end

  assign settling = |diff_w;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: a per-cycle vector table on a SETTLE=4
// instance plus sequences for async reset, reset mid-settle and auto-repeat.
module tb_key_debounce;

  logic clk;
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic       reset_a, reset_b;
  logic [7:0] keys_a, keys_b, out_a, out_b, rpt_a, rpt_b;
  logic       set_a, set_b;

  key_debounce #(.N(8), .SETTLE(4)) dut_a (
    .clk(clk), .reset(reset_a), .keys_in(keys_a),
    .keys_out(out_a), .settling(set_a), .rpt(rpt_a)
  );

  key_debounce #(.N(8), .SETTLE(8)) dut_b (
    .clk(clk), .reset(reset_b), .keys_in(keys_b),
    .keys_out(out_b), .settling(set_b), .rpt(rpt_b)
  );

`ifdef KEY_RPT_EN
  logic       reset_c;
  logic [7:0] keys_c, out_c, rpt_c;
  logic       set_c;

  key_debounce #(.N(8), .SETTLE(2), .RPT_DLY(5), .RPT_PER(3)) dut_c (
    .clk(clk), .reset(reset_c), .keys_in(keys_c),
    .keys_out(out_c), .settling(set_c), .rpt(rpt_c)
  );
`endif

  typedef struct {
    logic       rst;
    logic [7:0] keys;
    logic [7:0] exp_out;
    logic       exp_set;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] keys, input logic [7:0] eo, input logic es);
    vec_t v;
    v.rst = rst; v.keys = keys; v.exp_out = eo; v.exp_set = es;
    vecs.push_back(v);
  endtask

  // Clean SETTLE=4 transition: visible on the sixth row (edge E5).
  task automatic add_settle(input logic [7:0] keys, input logic [7:0] from, input logic [7:0] to);
    add(1'b0, keys, from, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, keys, from, 1'b1);
    add(1'b0, keys, to, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bounce_keys [18];
    logic       bounce_set  [18];

    reset_a = 1'b1; reset_b = 1'b1; keys_a = '0; keys_b = '0;
`ifdef KEY_RPT_EN
    reset_c = 1'b1; keys_c = '0;
`endif

    // Reset held with all keys pressed, then release and re-debounce.
    add(1'b1, 8'hFF, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 8'h00, 1'b0);
    add_settle(8'hFF, 8'h00, 8'hFF);
    add_settle(8'h00, 8'hFF, 8'h00);
    // Clean press and release of key 0.
    add_settle(8'h01, 8'h00, 8'h01);
    add_settle(8'h00, 8'h01, 8'h00);
    // Key 2 bounces in 3-cycle runs, then stays pressed.
    for (int j = 0; j < 18; j++) begin
      bounce_keys[j] = (j < 12 && ((j / 3) % 2) == 1) ? 8'h00 : 8'h04;
      bounce_set[j]  = 1'b0;
    end
    for (int j = 1; j < 17; j++) bounce_set[j] = (bounce_keys[j-1] != 8'h00);
    for (int j = 0; j < 18; j++)
      add(1'b0, bounce_keys[j], (j == 17) ? 8'h04 : 8'h00, bounce_set[j]);
    add_settle(8'h00, 8'h04, 8'h00);
    // Key 1 then key 5 two cycles later settle independently.
    add(1'b0, 8'h02, 8'h00, 1'b0);
    add(1'b0, 8'h02, 8'h00, 1'b1);
    for (int j = 2; j < 5; j++) add(1'b0, 8'h22, 8'h00, 1'b1);
    add(1'b0, 8'h22, 8'h02, 1'b1);
    add(1'b0, 8'h22, 8'h02, 1'b1);
    add(1'b0, 8'h22, 8'h22, 1'b0);

    foreach (vecs[k]) begin
      reset_a = vecs[k].rst;
      keys_a  = vecs[k].keys;
      tick();
      check($sformatf("vec%0d keys_out", k), {24'd0, out_a}, {24'd0, vecs[k].exp_out});
      check($sformatf("vec%0d settling", k), {31'd0, set_a}, {31'd0, vecs[k].exp_set});
      check($sformatf("vec%0d rpt", k), {24'd0, rpt_a}, 32'd0);
    end

    // Asynchronous reset clears a settled output with no clock edge.
    reset_a = 1'b1;
    #2;
    check("async_rst keys_out", {24'd0, out_a}, 32'd0);
    check("async_rst settling", {31'd0, set_a}, 32'd0);
    reset_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("redeb k%0d", k), {24'd0, out_a}, (k == 5) ? 32'h22 : 32'h00);
    end

    // Reset mid-settle on the SETTLE=8 instance.
    reset_b = 1'b0;
    tick(); tick();
    keys_b = 8'h08;
    tick(); tick(); tick();
    reset_b = 1'b1;
    #1;
    check("midrst keys_out", {24'd0, out_b}, 32'd0);
    check("midrst settling", {31'd0, set_b}, 32'd0);
    tick();
    reset_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("midrst k%0d keys_out", k), {24'd0, out_b}, (k == 9) ? 32'h08 : 32'h00);
      check($sformatf("midrst k%0d settling", k), {31'd0, set_b}, (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
    end

`ifdef KEY_RPT_EN
    reset_c = 1'b0;
    tick(); tick();
    keys_c = 8'h01;
    for (int k = 0; k < 17; k++) begin
      tick();
      check($sformatf("rpt k%0d keys_out", k), {24'd0, out_c}, (k >= 3) ? 32'h01 : 32'h00);
      check($sformatf("rpt k%0d pulse", k), {24'd0, rpt_c},
            (k >= 7 && ((k - 7) % 3) == 0) ? 32'h01 : 32'h00);
    end
    keys_c = 8'h00;
    begin
      int n;
      n = 0;
      while (out_c[0] !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      check("rpt release seen", {31'd0, out_c[0]}, 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rpt after release k%0d", k), {24'd0, rpt_c}, 32'd0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
